estagio_decode: RTL and testbench

// MIPS-subset instruction decode stage plus ID/EX pipeline register. Drives register-file read indices,

---
 rtl/estagio_decode.sv | 198 +++++++++++++++++++
 tb/tb_estagio_decode.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/estagio_decode.sv
// MIPS-subset decode stage with ID/EX pipeline register, WB->ID bypass,
// load-use hazard detection and branch-flush squash.
module estagio_decode #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit WB_BYPASS  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dec_in_valid,
  input  logic [31:0]           dec_in_instr,
  input  logic [DATA_W-1:0]     dec_in_pc4,
  input  logic                  dec_in_flush,
  output logic [REG_ADDR_W-1:0] dec_out_rs,
  output logic [REG_ADDR_W-1:0] dec_out_rt,
  input  logic [DATA_W-1:0]     dec_in_R_rs,
  input  logic [DATA_W-1:0]     dec_in_R_rt,
  input  logic                  wb_enable,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  dec_out_stall,
  output logic                  dec_out_valid,
  output logic [DATA_W-1:0]     dec_out_pc4,
  output logic [DATA_W-1:0]     dec_out_rs_val,
  output logic [DATA_W-1:0]     dec_out_rt_val,
  output logic [DATA_W-1:0]     dec_out_imm,
  output logic [REG_ADDR_W-1:0] dec_out_rs_idx,
  output logic [REG_ADDR_W-1:0] dec_out_rt_idx,
  output logic [REG_ADDR_W-1:0] dec_out_dest,
  output logic [2:0]            dec_out_alu_op,
  output logic                  dec_out_alu_src,
  output logic                  dec_out_reg_write,
  output logic                  dec_out_mem_read,
  output logic                  dec_out_mem_write,
  output logic                  dec_out_mem_to_reg,
  output logic                  dec_out_branch,
  output logic                  dec_out_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     pc4;
    logic [DATA_W-1:0]     rsVal;
    logic [DATA_W-1:0]     rtVal;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rsIdx;
    logic [REG_ADDR_W-1:0] rtIdx;
    logic [REG_ADDR_W-1:0] dest;
    logic [2:0]            aluOp;
    logic                  aluSrc;
    logic                  regWrite;
    logic                  memRead;
    logic                  memWrite;
    logic                  memToReg;
    logic                  branch;
    logic                  illegal;
  } idEx_t;

  idEx_t idExQ, idExD, decoded;

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rsIdx;
  logic [REG_ADDR_W-1:0] rtIdx;
  logic [REG_ADDR_W-1:0] rdIdx;
  logic                  legal;
  logic                  readsRt;
  logic                  writesReg;
  logic                  hazard;

  assign opcode = dec_in_instr[31:26];
  assign funct  = dec_in_instr[5:0];
  assign rsIdx  = dec_in_instr[25:21];
  assign rtIdx  = dec_in_instr[20:16];
  assign rdIdx  = dec_in_instr[15:11];

  assign dec_out_rs = rsIdx;
  assign dec_out_rt = rtIdx;

  // Field decode of the IF/ID instruction; only meaningful when legal=1.
  always_comb begin
    decoded   = '0;
    legal     = 1'b0;
    readsRt   = 1'b0;
    writesReg = 1'b0;
    decoded.valid = 1'b1;
    decoded.pc4   = dec_in_pc4;
    decoded.imm   = {{(DATA_W-16){dec_in_instr[15]}}, dec_in_instr[15:0]};
    decoded.rsIdx = rsIdx;
    decoded.rtIdx = rtIdx;
    decoded.rsVal = (WB_BYPASS && wb_enable && wb_dest != '0 && wb_dest == rsIdx)
                    ? wb_data : dec_in_R_rs;
    decoded.rtVal = (WB_BYPASS && wb_enable && wb_dest != '0 && wb_dest == rtIdx)
                    ? wb_data : dec_in_R_rt;
    case (opcode)
      OP_RTYPE: begin
        readsRt      = 1'b1;
        writesReg    = 1'b1;
        decoded.dest = rdIdx;
        legal        = 1'b1;
        case (funct)
          FN_ADD:  decoded.aluOp = 3'd0;
          FN_SUB:  decoded.aluOp = 3'd1;
          FN_AND:  decoded.aluOp = 3'd2;
          FN_OR:   decoded.aluOp = 3'd3;
          FN_SLT:  decoded.aluOp = 3'd4;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        legal          = 1'b1;
        writesReg      = 1'b1;
        decoded.dest   = rtIdx;
        decoded.aluSrc = 1'b1;
      end
      OP_LW: begin
        legal            = 1'b1;
        writesReg        = 1'b1;
        decoded.dest     = rtIdx;
        decoded.aluSrc   = 1'b1;
        decoded.memRead  = 1'b1;
        decoded.memToReg = 1'b1;
      end
      OP_SW: begin
        legal            = 1'b1;
        readsRt          = 1'b1;
        decoded.aluSrc   = 1'b1;
        decoded.memWrite = 1'b1;
      end
      OP_BEQ: begin
        legal          = 1'b1;
        readsRt        = 1'b1;
        decoded.aluOp  = 3'd1;
        decoded.branch = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Writes to $0 are architecturally discarded, so never request them.
    decoded.regWrite = writesReg && (decoded.dest != '0);
  end

  assign hazard = ex_mem_read && idExQ.valid && (ex_dest != '0) &&
                  ((ex_dest == rsIdx) || ((ex_dest == rtIdx) && readsRt));

  // A taken branch squashes the instruction, so it must not also hold fetch.
  assign dec_out_stall = dec_in_valid && !dec_in_flush && hazard;

  always_comb begin
    idExD = '0;
    if (!dec_in_flush && !dec_out_stall && dec_in_valid) begin
      if (legal) begin
        idExD = decoded;
      end else begin
        idExD.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idExQ <= '0;
    end else begin
      idExQ <= idExD;
    end
  end

  assign dec_out_valid      = idExQ.valid;
  assign dec_out_pc4        = idExQ.pc4;
  assign dec_out_rs_val     = idExQ.rsVal;
  assign dec_out_rt_val     = idExQ.rtVal;
  assign dec_out_imm        = idExQ.imm;
  assign dec_out_rs_idx     = idExQ.rsIdx;
  assign dec_out_rt_idx     = idExQ.rtIdx;
  assign dec_out_dest       = idExQ.dest;
  assign dec_out_alu_op     = idExQ.aluOp;
  assign dec_out_alu_src    = idExQ.aluSrc;
  assign dec_out_reg_write  = idExQ.regWrite;
  assign dec_out_mem_read   = idExQ.memRead;
  assign dec_out_mem_write  = idExQ.memWrite;
  assign dec_out_mem_to_reg = idExQ.memToReg;
  assign dec_out_branch     = idExQ.branch;
  assign dec_out_illegal    = idExQ.illegal;

endmodule

// File: tb/tb_estagio_decode.sv
// Directed and randomized bench for estagio_decode, checked against a
// behavioural model of the decode rules and the ID/EX stage it fills.
module tb_estagio_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic        dec_in_valid;
  logic [31:0] dec_in_instr;
  logic [31:0] dec_in_pc4;
  logic        dec_in_flush;
  logic [4:0]  dec_out_rs;
  logic [4:0]  dec_out_rt;
  logic [31:0] dec_in_R_rs;
  logic [31:0] dec_in_R_rt;
  logic        wb_enable;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_dest;
  logic        dec_out_stall;
  logic        dec_out_valid;
  logic [31:0] dec_out_pc4;
  logic [31:0] dec_out_rs_val;
  logic [31:0] dec_out_rt_val;
  logic [31:0] dec_out_imm;
  logic [4:0]  dec_out_rs_idx;
  logic [4:0]  dec_out_rt_idx;
  logic [4:0]  dec_out_dest;
  logic [2:0]  dec_out_alu_op;
  logic        dec_out_alu_src;
  logic        dec_out_reg_write;
  logic        dec_out_mem_read;
  logic        dec_out_mem_write;
  logic        dec_out_mem_to_reg;
  logic        dec_out_branch;
  logic        dec_out_illegal;

  always #5 clock = ~clock;

  estagio_decode dut (
    .clock(clock), .reset(reset),
    .dec_in_valid(dec_in_valid), .dec_in_instr(dec_in_instr),
    .dec_in_pc4(dec_in_pc4), .dec_in_flush(dec_in_flush),
    .dec_out_rs(dec_out_rs), .dec_out_rt(dec_out_rt),
    .dec_in_R_rs(dec_in_R_rs), .dec_in_R_rt(dec_in_R_rt),
    .wb_enable(wb_enable), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .dec_out_stall(dec_out_stall), .dec_out_valid(dec_out_valid),
    .dec_out_pc4(dec_out_pc4), .dec_out_rs_val(dec_out_rs_val),
    .dec_out_rt_val(dec_out_rt_val), .dec_out_imm(dec_out_imm),
    .dec_out_rs_idx(dec_out_rs_idx), .dec_out_rt_idx(dec_out_rt_idx),
    .dec_out_dest(dec_out_dest), .dec_out_alu_op(dec_out_alu_op),
    .dec_out_alu_src(dec_out_alu_src), .dec_out_reg_write(dec_out_reg_write),
    .dec_out_mem_read(dec_out_mem_read), .dec_out_mem_write(dec_out_mem_write),
    .dec_out_mem_to_reg(dec_out_mem_to_reg), .dec_out_branch(dec_out_branch),
    .dec_out_illegal(dec_out_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4, rsVal, rtVal, imm;
    logic [4:0]  rsIdx, rtIdx, dest;
    logic [2:0]  aluOp;
    logic        aluSrc, regWrite, memRead, memWrite, memToReg, branch, illegal;
  } stage_t;

  int     checks = 0;
  int     errors = 0;
  stage_t expStage = '0;
  logic   lastStall = 1'b0;
  logic   obsStall = 1'b0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // What the ID/EX register should hold after an edge, from the ISA rules.
  function automatic stage_t modelNext(input logic rst, input logic vld, input logic fl,
                                       input logic stl, input logic [31:0] ins,
                                       input logic [31:0] pc, input logic [31:0] rRs,
                                       input logic [31:0] rRt, input logic wEn,
                                       input logic [4:0] wDst, input logic [31:0] wDat);
    stage_t s = '0;
    int     op = int'(ins[31:26]);
    int     fn = int'(ins[5:0]);
    int     rsN = int'(ins[25:21]);
    int     rtN = int'(ins[20:16]);
    int     rdN = int'(ins[15:11]);
    int     destN = 0;
    bit     ok = 1'b1;
    bit     writes = 1'b0;
    if (rst || fl || stl || !vld) return s;
    if (op == 0) begin
      writes = 1'b1;
      destN  = rdN;
      if (fn == 32) s.aluOp = 3'd0;
      else if (fn == 34) s.aluOp = 3'd1;
      else if (fn == 36) s.aluOp = 3'd2;
      else if (fn == 37) s.aluOp = 3'd3;
      else if (fn == 42) s.aluOp = 3'd4;
      else ok = 1'b0;
    end else if (op == 8) begin
      writes = 1'b1; destN = rtN; s.aluSrc = 1'b1;
    end else if (op == 35) begin
      writes = 1'b1; destN = rtN; s.aluSrc = 1'b1; s.memRead = 1'b1; s.memToReg = 1'b1;
    end else if (op == 43) begin
      s.aluSrc = 1'b1; s.memWrite = 1'b1;
    end else if (op == 4) begin
      s.aluOp = 3'd1; s.branch = 1'b1;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      s = '0;
      s.illegal = 1'b1;
      return s;
    end
    s.valid    = 1'b1;
    s.pc4      = pc;
    s.imm      = 32'(signed'(ins[15:0]));
    s.rsIdx    = 5'(rsN);
    s.rtIdx    = 5'(rtN);
    s.dest     = 5'(destN);
    s.regWrite = writes && (destN != 0);
    s.rsVal    = (wEn && wDst != 0 && int'(wDst) == rsN) ? wDat : rRs;
    s.rtVal    = (wEn && wDst != 0 && int'(wDst) == rtN) ? wDat : rRt;
    return s;
  endfunction

  task automatic checkOutput();
    check("valid",      32'(dec_out_valid),      32'(expStage.valid));
    check("pc4",        dec_out_pc4,             expStage.pc4);
    check("rs_val",     dec_out_rs_val,          expStage.rsVal);
    check("rt_val",     dec_out_rt_val,          expStage.rtVal);
    check("imm",        dec_out_imm,             expStage.imm);
    check("rs_idx",     32'(dec_out_rs_idx),     32'(expStage.rsIdx));
    check("rt_idx",     32'(dec_out_rt_idx),     32'(expStage.rtIdx));
    check("dest",       32'(dec_out_dest),       32'(expStage.dest));
    check("alu_op",     32'(dec_out_alu_op),     32'(expStage.aluOp));
    check("alu_src",    32'(dec_out_alu_src),    32'(expStage.aluSrc));
    check("reg_write",  32'(dec_out_reg_write),  32'(expStage.regWrite));
    check("mem_read",   32'(dec_out_mem_read),   32'(expStage.memRead));
    check("mem_write",  32'(dec_out_mem_write),  32'(expStage.memWrite));
    check("mem_to_reg", 32'(dec_out_mem_to_reg), 32'(expStage.memToReg));
    check("branch",     32'(dec_out_branch),     32'(expStage.branch));
    check("illegal",    32'(dec_out_illegal),    32'(expStage.illegal));
  endtask

  // Drives one cycle of inputs after a falling edge, checks the combinational
  // outputs, clocks the DUT and checks the ID/EX register on the next falling edge.
  task automatic applyStimulus(input logic rst, input logic vld, input logic [31:0] ins,
                               input logic [31:0] pc, input logic fl,
                               input logic [31:0] rRs, input logic [31:0] rRt,
                               input logic wEn, input logic [4:0] wDst,
                               input logic [31:0] wDat);
    logic   readsRt;
    logic   hz;
    logic   expStall;
    stage_t nxt;
    reset = rst; dec_in_valid = vld; dec_in_instr = ins; dec_in_pc4 = pc;
    dec_in_flush = fl; dec_in_R_rs = rRs; dec_in_R_rt = rRt;
    wb_enable = wEn; wb_dest = wDst; wb_data = wDat;
    ex_mem_read = expStage.memRead;
    ex_dest = expStage.dest;
    readsRt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
    hz = expStage.memRead && expStage.valid && (expStage.dest != 0) &&
         ((expStage.dest == ins[25:21]) || ((expStage.dest == ins[20:16]) && readsRt));
    expStall = vld && !fl && hz;
    #1;
    obsStall = dec_out_stall;
    check("stall", 32'(dec_out_stall), 32'(expStall));
    check("rs_out", 32'(dec_out_rs), 32'(ins[25:21]));
    check("rt_out", 32'(dec_out_rt), 32'(ins[20:16]));
    nxt = modelNext(rst, vld, fl, expStall, ins, pc, rRs, rRt, wEn, wDst, wDat);
    @(posedge clock);
    expStage = nxt;
    lastStall = expStall;
    @(negedge clock);
    checkOutput();
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0] a = 5'($urandom_range(0, 5));
    logic [4:0] b = 5'($urandom_range(0, 5));
    logic [4:0] c = 5'($urandom_range(0, 5));
    logic [15:0] k = 16'($urandom);
    case ($urandom_range(0, 10))
      0:  return {6'h00, a, b, c, 5'd0, 6'h20};
      1:  return {6'h00, a, b, c, 5'd0, 6'h22};
      2:  return {6'h00, a, b, c, 5'd0, 6'h24};
      3:  return {6'h00, a, b, c, 5'd0, 6'h25};
      4:  return {6'h00, a, b, c, 5'd0, 6'h2A};
      5:  return {6'h08, a, b, k};
      6:  return {6'h23, a, b, k};
      7:  return {6'h2B, a, b, k};
      8:  return {6'h04, a, b, k};
      9:  return {6'h00, a, b, c, 5'd0, 6'($urandom_range(0, 31))};
      default: return {6'($urandom_range(48, 63)), a, b, k};
    endcase
  endfunction

  initial begin
    logic [31:0] ins;
    logic [31:0] pc;
    logic        vld;
    $display("[TB] estagio_decode bench starting");
    reset = 1'b1; dec_in_valid = 1'b0; dec_in_instr = '0; dec_in_pc4 = '0;
    dec_in_flush = 1'b0; dec_in_R_rs = '0; dec_in_R_rt = '0;
    wb_enable = 1'b0; wb_dest = '0; wb_data = '0; ex_mem_read = 1'b0; ex_dest = '0;
    @(negedge clock);

    // Power-on reset leaves a bubble.
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    check("rst_valid", 32'(dec_out_valid), 0);

    // add $3,$1,$2 with plain register-file operands.
    applyStimulus(0, 1, 32'h00221820, 32'h104, 0, 5, 7, 0, 0, 0);
    check("t2_valid", 32'(dec_out_valid), 1);
    check("t2_dest", 32'(dec_out_dest), 3);
    check("t2_alu_op", 32'(dec_out_alu_op), 0);
    check("t2_rs_val", dec_out_rs_val, 5);
    check("t2_rt_val", dec_out_rt_val, 7);

    // lw $4,8($1) followed by a dependent add: exactly one bubble.
    applyStimulus(0, 1, 32'h8C240008, 32'h108, 0, 32'h40, 0, 0, 0, 0);
    check("t3_lw_mem_read", 32'(dec_out_mem_read), 1);
    applyStimulus(0, 1, 32'h00822820, 32'h10C, 0, 1, 2, 0, 0, 0);
    check("t3_stall", 32'(obsStall), 1);
    check("t3_bubble", 32'(dec_out_valid), 0);
    applyStimulus(0, 1, 32'h00822820, 32'h10C, 0, 1, 2, 0, 0, 0);
    check("t3_stall_clear", 32'(obsStall), 0);
    check("t3_rs_idx", 32'(dec_out_rs_idx), 4);
    check("t3_dest", 32'(dec_out_dest), 5);

    // WB bypass onto rt, then wb_dest=0 must not bypass.
    applyStimulus(0, 1, 32'h00221820, 32'h110, 0, 9, 0, 1, 2, 32'hDEAD);
    check("t4_bypass_rt", dec_out_rt_val, 32'hDEAD);
    applyStimulus(0, 1, 32'h00221820, 32'h114, 0, 9, 32'h11, 1, 0, 32'hDEAD);
    check("t4_no_bypass_r0", dec_out_rt_val, 32'h11);

    // Flush while a load-use hazard is present, then an illegal opcode.
    applyStimulus(0, 1, 32'h8C240008, 32'h118, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h00822820, 32'h11C, 1, 0, 0, 0, 0, 0);
    check("t5_flush_stall", 32'(obsStall), 0);
    check("t5_flush_bubble", 32'(dec_out_valid), 0);
    applyStimulus(0, 1, 32'hFC000000, 32'h120, 0, 0, 0, 0, 0, 0);
    check("t5_illegal", 32'(dec_out_illegal), 1);
    check("t5_illegal_valid", 32'(dec_out_valid), 0);
    applyStimulus(0, 0, 32'h0, 32'h124, 0, 0, 0, 0, 0, 0);
    check("t5_illegal_pulse", 32'(dec_out_illegal), 0);

    // addi $0,$1,-1: sign-extended immediate, no write to $0.
    applyStimulus(0, 1, 32'h2020FFFF, 32'h128, 0, 3, 0, 0, 0, 0);
    check("t6_imm", dec_out_imm, 32'hFFFFFFFF);
    check("t6_reg_write", 32'(dec_out_reg_write), 0);
    check("t6_valid", 32'(dec_out_valid), 1);

    // Reset asserted mid-stall for two cycles.
    applyStimulus(0, 1, 32'h8C240008, 32'h12C, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h00822820, 32'h130, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h00822820, 32'h130, 0, 0, 0, 0, 0, 0);
    check("t1_stall_after_reset", 32'(obsStall), 0);
    check("t1_valid", 32'(dec_out_valid), 0);
    check("t1_mem_read", 32'(dec_out_mem_read), 0);
    applyStimulus(0, 1, 32'h00822820, 32'h130, 0, 4, 6, 0, 0, 0);
    check("t1_resume_stall", 32'(obsStall), 0);
    check("t1_resume_valid", 32'(dec_out_valid), 1);

    // Randomized stream; fetch holds its instruction whenever decode stalls.
    ins = 32'h0; pc = 32'h200; vld = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!lastStall) begin
        ins = randInstr();
        pc  = pc + 4;
        vld = ($urandom_range(0, 9) != 0);
      end
      applyStimulus(($urandom_range(0, 99) == 0), vld, ins, pc,
                    ($urandom_range(0, 11) == 0), $urandom, $urandom,
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 5)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
